// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode codes,
// sequencer state encoding and the default shift-amount width.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ASHR = 3'd4;
  localparam logic [2:0] MODE_ROTL = 3'd5;
  localparam logic [2:0] MODE_ROTR = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Amount field must be able to express 0..width inclusive.
  function automatic int amt_w_for(input int width);
    return $clog2(width) + 1;
  endfunction

  // Shift and rotate modes are the only ones that move bits through sout
  // and the only ones a start request may sequence.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ROTR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a requester and the universal shift register.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = usr_pkg::amt_w_for(WIDTH)
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output en, mode, d, sin, start, amt,
    input  q, sout, busy, done, zero
  );

  modport slave (
    input  en, mode, d, sin, start, amt,
    output q, sout, busy, done, zero
  );
endinterface

// File: rtl/univ_shift_reg_step.sv
// One-position datapath step shared by single-cycle operations and the
// sequenced RUN path, so both produce bit-identical results.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit,
  output logic             shifted
);

  // Next register value and the bit leaving the register for this op.
  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    shifted = is_shift_mode(op);
    case (op)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], sin};
        out_bit = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {sin, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ASHR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROTL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      MODE_ROTR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_CLR: q_next = '0;
      default:  q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a start/busy/done multi-position sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | single-cycle ops on each enabled edge; accepts start
// ST_RUN  | applies latched op once per enabled edge until cnt expires
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = amt_w_for(WIDTH)
) (
  input logic              clk,
  input logic              reset,
  univ_shift_reg_if.slave  bus
);

  state_t           state;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] q_r;
  logic             sout_r;
  logic             busy_r;
  logic             done_r;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] q_next;
  logic             out_bit;
  logic             shifted;

  // During RUN the latched op drives the datapath; mode is ignored.
  assign op_sel = (state == ST_RUN) ? op_r : bus.mode;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_r),
    .op      (op_sel),
    .sin     (bus.sin),
    .d       (bus.d),
    .q_next  (q_next),
    .out_bit (out_bit),
    .shifted (shifted)
  );

  // Sequencer, counter and output registers; done is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      op_r   <= MODE_HOLD;
      cnt    <= '0;
      q_r    <= '0;
      sout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            if (bus.start && is_shift_mode(bus.mode)) begin
              // Start edge only latches the request; q moves from next edge.
              op_r <= bus.mode;
              cnt  <= bus.amt;
              if (bus.amt != '0) begin
                state  <= ST_RUN;
                busy_r <= 1'b1;
              end else begin
                done_r <= 1'b1;
              end
            end else begin
              q_r <= q_next;
              if (shifted) sout_r <= out_bit;
            end
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            q_r    <= q_next;
            sout_r <= out_bit;
            cnt    <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.zero = (q_r == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus
// a randomized run against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int A = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  univ_shift_reg_if #(.WIDTH(W), .AMT_W(A)) bus ();

  univ_shift_reg #(.WIDTH(W), .AMT_W(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [2:0] mode, input logic [7:0] d,
                       input logic sin, input logic start, input logic [3:0] amt);
    bus.en = en; bus.mode = mode; bus.d = d; bus.sin = sin;
    bus.start = start; bus.amt = amt;
  endtask

  task automatic load(input logic [7:0] v);
    drive(1, 3'd1, v, 0, 0, 0);
    cyc();
    drive(1, 3'd0, 8'h00, 0, 0, 0);
  endtask

  // Reference: one operation computed with integer arithmetic.
  function automatic void ref_apply(input int q, input int m, input int s, input int dv,
                                    output int qn, output int so, output int moved);
    qn = q; so = 0; moved = 1;
    case (m)
      0: begin qn = q;  moved = 0; end
      1: begin qn = dv; moved = 0; end
      2: begin qn = (q * 2 + s) % 256;            so = q / 128; end
      3: begin qn = q / 2 + s * 128;              so = q % 2; end
      4: begin qn = q / 2 + (q / 128) * 128;      so = q % 2; end
      5: begin qn = (q * 2) % 256 + q / 128;      so = q / 128; end
      6: begin qn = q / 2 + (q % 2) * 128;        so = q % 2; end
      default: begin qn = 0; moved = 0; end
    endcase
  endfunction

  task automatic test_reset();
    load(8'hA5);
    drive(1, 3'd6, 8'h00, 0, 1, 4'd5);
    cyc();
    drive(1, 3'd0, 8'h00, 0, 0, 0);
    cyc();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.sout !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async q=%h sout=%b busy=%b done=%b want 00 0 0 0",
               bus.q, bus.sout, bus.busy, bus.done);
    end
    checks++;
    if (bus.zero !== 1'b1) begin
      failures++; $display("FAIL reset_zero zero=%b want 1", bus.zero);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 3'd1, 8'h3C, 0, 0, 0);
    cyc();
    checks++;
    if (bus.q !== 8'h3C || bus.zero !== 1'b0) begin
      failures++; $display("FAIL reset_load q=%h zero=%b want 3c 0", bus.q, bus.zero);
    end
  endtask

  task automatic test_single_step();
    logic [7:0] eq [3];
    logic       es [3];
    logic [2:0] md [3];
    eq = '{8'h03, 8'h07, 8'h03};
    es = '{1'b1, 1'b0, 1'b1};
    md = '{3'd5, 3'd2, 3'd4};
    load(8'h81);
    for (int i = 0; i < 3; i++) begin
      drive(1, md[i], 8'h00, 1, 0, 0);
      cyc();
      checks++;
      if (bus.q !== eq[i] || bus.sout !== es[i]) begin
        failures++;
        $display("FAIL single_step[%0d] q=%h sout=%b want %h %b", i, bus.q, bus.sout, eq[i], es[i]);
      end
    end
  endtask

  // Shared by the plain and paused multi-shift scenarios.
  task automatic run_rotr3(input bit pause, input string tag);
    logic [7:0] eq [6];
    logic       eb [6];
    logic       ed [6];
    logic       en_seq [6];
    int n;
    if (pause) begin
      eq = '{8'hF0, 8'h78, 8'h78, 8'h78, 8'h3C, 8'h1E};
      eb = '{1, 1, 1, 1, 1, 0};
      ed = '{0, 0, 0, 0, 0, 1};
      en_seq = '{1, 1, 0, 0, 1, 1};
      n = 6;
    end else begin
      eq = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h00, 8'h00};
      eb = '{1, 1, 1, 0, 0, 0};
      ed = '{0, 0, 0, 1, 0, 0};
      en_seq = '{1, 1, 1, 1, 1, 1};
      n = 4;
    end
    load(8'hF0);
    drive(1, 3'd6, 8'h00, 0, 1, 4'd3);
    for (int i = 0; i < n; i++) begin
      bus.en = en_seq[i];
      cyc();
      bus.start = 0; bus.mode = 3'd0;
      checks++;
      if (bus.q !== eq[i] || bus.busy !== eb[i] || bus.done !== ed[i]) begin
        failures++;
        $display("FAIL %s[%0d] q=%h busy=%b done=%b want %h %b %b",
                 tag, i, bus.q, bus.busy, bus.done, eq[i], eb[i], ed[i]);
      end
    end
    bus.en = 1;
    cyc();
    checks++;
    if (bus.done !== 1'b0 || bus.q !== 8'h1E) begin
      failures++; $display("FAIL %s_after done=%b q=%h want 0 1e", tag, bus.done, bus.q);
    end
  endtask

  task automatic test_multi_shift();
    run_rotr3(0, "multi_shift");
  endtask

  task automatic test_pause();
    run_rotr3(1, "pause");
  endtask

  task automatic test_amt_zero_and_load();
    load(8'h5A);
    drive(1, 3'd2, 8'h00, 1, 1, 4'd0);
    cyc();
    drive(1, 3'd0, 8'h00, 0, 0, 0);
    checks++;
    if (bus.q !== 8'h5A || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL amt_zero q=%h busy=%b done=%b want 5a 0 1", bus.q, bus.busy, bus.done);
    end
    cyc();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL amt_zero_clear done=%b want 0", bus.done);
    end
    drive(1, 3'd1, 8'hC3, 0, 1, 4'd3);
    cyc();
    drive(1, 3'd0, 8'h00, 0, 0, 0);
    checks++;
    if (bus.q !== 8'hC3 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL start_load q=%h busy=%b done=%b want c3 0 0", bus.q, bus.busy, bus.done);
    end
    cyc();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL start_load_done done=%b want 0", bus.done);
    end
  endtask

  task automatic test_ignore_and_abort();
    logic [7:0] eq [4];
    int dcount;
    eq = '{8'h7F, 8'h3F, 8'h1F, 8'h0F};
    load(8'hFF);
    drive(1, 3'd3, 8'h00, 0, 1, 4'd4);
    cyc();
    drive(1, 3'd7, 8'hAA, 0, 1, 4'd2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.q !== eq[i] || bus.done !== (i == 3)) begin
        failures++;
        $display("FAIL ignore_in_run[%0d] q=%h done=%b want %h %b", i, bus.q, bus.done, eq[i], i == 3);
      end
    end
    drive(1, 3'd0, 8'h00, 0, 0, 0);
    cyc();
    drive(1, 3'd5, 8'h00, 0, 1, 4'd6);
    cyc();
    drive(1, 3'd0, 8'h00, 0, 0, 0);
    cyc();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL abort q=%h busy=%b want 00 0", bus.q, bus.busy);
    end
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      failures++; $display("FAIL abort_no_done cycles_with_done_or_busy=%0d want 0", dcount);
    end
  endtask

  task automatic test_back_to_back();
    load(8'h96);
    drive(1, 3'd5, 8'h00, 0, 1, 4'd8);
    cyc();
    drive(1, 3'd0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc();
    checks++;
    if (bus.q !== 8'h96 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rot_full q=%h done=%b busy=%b want 96 1 0", bus.q, bus.done, bus.busy);
    end
    drive(1, 3'd6, 8'h00, 0, 1, 4'd1);
    cyc();
    drive(1, 3'd0, 8'h00, 0, 0, 0);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.q !== 8'h96) begin
      failures++;
      $display("FAIL b2b_accept busy=%b done=%b q=%h want 1 0 96", bus.busy, bus.done, bus.q);
    end
    cyc();
    checks++;
    if (bus.q !== 8'h4B || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_finish q=%h done=%b busy=%b want 4b 1 0", bus.q, bus.done, bus.busy);
    end
  endtask

  task automatic test_random();
    int m_q, m_sout, m_busy, m_done, m_op, m_left;
    int qn, so, moved;
    int errs;
    cyc();
    m_q = bus.q; m_sout = bus.sout; m_busy = 0; m_done = 0; m_op = 0; m_left = 0;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 11)));
      m_done = 0;
      if (m_busy == 0) begin
        if (bus.en) begin
          if (bus.start && bus.mode >= 2 && bus.mode <= 6) begin
            m_op = bus.mode; m_left = bus.amt;
            if (m_left > 0) m_busy = 1; else m_done = 1;
          end else begin
            ref_apply(m_q, bus.mode, bus.sin, bus.d, qn, so, moved);
            m_q = qn;
            if (moved != 0) m_sout = so;
          end
        end
      end else if (bus.en) begin
        ref_apply(m_q, m_op, bus.sin, bus.d, qn, so, moved);
        m_q = qn; m_sout = so;
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
      cyc();
      checks++;
      if (bus.q !== 8'(m_q) || bus.sout !== 1'(m_sout) || bus.busy !== 1'(m_busy) ||
          bus.done !== 1'(m_done) || bus.zero !== (m_q == 0)) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d] q=%h sout=%b busy=%b done=%b zero=%b want %h %0d %0d %0d %0d",
                   c, bus.q, bus.sout, bus.busy, bus.done, bus.zero,
                   8'(m_q), m_sout, m_busy, m_done, m_q == 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    drive(0, 3'd0, 8'h00, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_step();
    test_multi_shift();
    test_pause();
    test_amt_zero_and_load();
    test_ignore_and_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
